serial_subtractor: RTL

//   Bit-serial unsigned subtractor, the inverse arithmetic companion to the half/full adder cells.

---
 rtl/serial_subtractor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b over WIDTH cycles, LSB first, valid/ready on both sides.
// Optional macro SUB_OVERFLOW_EN adds the signed-overflow output ovf.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for operands, in_ready high
// ST_SHIFT | one result bit per cycle, WIDTH cycles, inputs ignored
// ST_DONE  | result presented with out_valid, held until out_ready
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic             a0, b0;
    logic             hs_d, hs_b;
    logic             d_bit, br_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] d_ext;

    // Full subtractor built from two half subtractors: (a0 - b0) then (that - br_q).
    always_comb begin
        a0       = opa_q[0];
        b0       = opb_q[0];
        hs_d     = a0 ^ b0;
        hs_b     = ~a0 & b0;
        d_bit    = hs_d ^ br_q;
        br_nxt   = hs_b | (~hs_d & br_q);
        d_ext    = WIDTH'(d_bit);
        last_bit = (cnt_q == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid)  state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        diff      = diff_q;
        bout      = bout_q;
    end

    // The minuend register doubles as the result register: result bits enter at the
    // MSB as operand bits leave at the LSB. diff/bout get their own copy so they stay
    // put while the next operation is shifting.
    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        cnt_d  = cnt_q;
        br_d   = br_q;
        diff_d = diff_q;
        bout_d = bout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opa_d = a;
                    opb_d = b;
                    cnt_d = '0;
                    br_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                opa_d = (opa_q >> 1) | (d_ext << (WIDTH - 1));
                opb_d = opb_q >> 1;
                br_d  = br_nxt;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    diff_d = opa_d;
                    bout_d = br_nxt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q  <= '0;
            opb_q  <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            bout_q <= 1'b0;
        end else begin
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            diff_q <= diff_d;
            cnt_q  <= cnt_d;
            br_q   <= br_d;
            bout_q <= bout_d;
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic ovf_q, ovf_d;

    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_SHIFT && last_bit) begin
            ovf_d = br_q ^ br_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
